// File: rtl/lbus_pkg.sv
// Shared LBUS segment constants, segment record and the TX framing state type.
package lbus_pkg;
  localparam int SEG_W     = 128;
  localparam int SEG_BYTES = 16;
  localparam int MTY_W     = 4;
  localparam int NSEG      = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  typedef struct packed {
    logic [SEG_W-1:0] data;
    logic             ena;
    logic             sop;
    logic             eop;
    logic             err;
    logic [MTY_W-1:0] mty;
  } seg_t;

  // LBUS counts bytes from the MSB end, AXIS from bit 0.
  function automatic logic [SEG_BYTES-1:0] keep_rev16(input logic [SEG_BYTES-1:0] k);
    logic [SEG_BYTES-1:0] r;
    for (int j = 0; j < SEG_BYTES; j++) r[j] = k[SEG_BYTES-1-j];
    return r;
  endfunction
endpackage

// File: rtl/axis2lbus_tx_if.sv
// 512-bit AXI4-Stream beat channel feeding the LBUS transmitter.
interface axis2lbus_tx_if;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic         tlast;
  logic         tuser;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/axis2lbus_tx_keep2mty.sv
// Converts a bit-reversed 16-bit segment keep into an LBUS empty-byte count.
module keep2mty
  import lbus_pkg::*;
(
  input  logic [SEG_BYTES-1:0] keep_rev,
  output logic [MTY_W-1:0]     mty
);
  logic [4:0] nvalid;
  logic [4:0] nempty;
  logic       run;

  // Valid bytes are the leading ones counted from the MSB; 16 empty wraps to 0.
  always_comb begin
    nvalid = '0;
    run    = 1'b1;
    for (int j = SEG_BYTES-1; j >= 0; j--) begin
      run    = run & keep_rev[j];
      nvalid = nvalid + {4'd0, run};
    end
    nempty = 5'd16 - nvalid;
    mty    = nempty[MTY_W-1:0];
  end
endmodule

// File: rtl/axis2lbus_tx.sv
// AXIS 512-bit to CMAC 4-segment LBUS transmit adapter with framing, checks and stats.
module axis2lbus_tx #(
  parameter int NSEG       = 4,
  parameter int BYTE_CNT_W = 48
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axis2lbus_tx_if.slave         s_axis,
  output logic [127:0]          tx_datain0, tx_datain1, tx_datain2, tx_datain3,
  output logic                  tx_enain0, tx_enain1, tx_enain2, tx_enain3,
  output logic                  tx_sopin0, tx_sopin1, tx_sopin2, tx_sopin3,
  output logic                  tx_eopin0, tx_eopin1, tx_eopin2, tx_eopin3,
  output logic                  tx_errin0, tx_errin1, tx_errin2, tx_errin3,
  output logic [3:0]            tx_mtyin0, tx_mtyin1, tx_mtyin2, tx_mtyin3,
  input  logic                  tx_rdyout,
  input  logic                  tx_unfout,
  output logic [31:0]           stat_pkts,
  output logic [BYTE_CNT_W-1:0] stat_bytes,
  output logic [15:0]           stat_bubbles,
  output logic                  keep_err,
  output logic                  unf_err
);
  import lbus_pkg::*;

  state_t           state_reg, state_next;
  logic             rdy_q;
  logic             acc;
  logic             keep_full, keep_contig, bad_nonlast, bad_keep;
  logic [NSEG-1:0]  seg_any;
  logic [1:0]       eop_seg;
  logic [6:0]       last_bytes;
  logic [SEG_W-1:0] seg_data [NSEG];
  logic [MTY_W-1:0] mty_raw  [NSEG];
  seg_t             seg_next [NSEG];
  seg_t             seg_reg  [NSEG];

  assign s_axis.tready = rdy_q;
  assign acc           = s_axis.tvalid & rdy_q;
  assign keep_full     = &s_axis.tkeep;
  // Contiguous-from-bit-0 masks are exactly those with keep & (keep+1) == 0.
  assign keep_contig   = ((s_axis.tkeep & (s_axis.tkeep + 64'd1)) == 64'd0);
  assign bad_nonlast   = !s_axis.tlast && !keep_full;
  assign bad_keep      = bad_nonlast || !keep_contig || (s_axis.tlast && (s_axis.tkeep == 64'd0));

  for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
    assign seg_any[gi] = |s_axis.tkeep[16*gi +: 16];
    keep2mty u_keep2mty (
      .keep_rev (keep_rev16(s_axis.tkeep[16*gi +: 16])),
      .mty      (mty_raw[gi])
    );
    for (genvar gk = 0; gk < SEG_BYTES; gk++) begin : g_byte
      assign seg_data[gi][SEG_W-1-8*gk -: 8] = s_axis.tdata[8*(16*gi+gk) +: 8];
    end
  end

  always_comb begin
    eop_seg = 2'd0;
    for (int i = 0; i < NSEG; i++) if (seg_any[i]) eop_seg = 2'(i);
    if (bad_nonlast) eop_seg = 2'd3;
  end

  assign last_bytes = {1'b0, eop_seg, 4'd0} + (7'd16 - {3'd0, mty_raw[eop_seg]});

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // An illegal keep on a non-last beat closes the packet early.
  always_comb begin
    state_next = state_reg;
    if (acc) state_next = (s_axis.tlast || bad_nonlast) ? IDLE : IN_PKT;
  end

  always_comb begin
    logic eop_i;
    for (int i = 0; i < NSEG; i++) begin
      eop_i              = acc && (s_axis.tlast || bad_nonlast) && (2'(i) == eop_seg);
      seg_next[i].data   = seg_data[i];
      seg_next[i].ena    = acc && (!s_axis.tlast || (2'(i) <= eop_seg));
      seg_next[i].sop    = acc && (i == 0) && (state_reg == IDLE);
      seg_next[i].eop    = eop_i;
      seg_next[i].err    = eop_i && (s_axis.tuser || bad_keep);
      seg_next[i].mty    = eop_i ? mty_raw[i] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NSEG; i++) seg_reg[i] <= '0;
      rdy_q        <= 1'b0;
      stat_pkts    <= '0;
      stat_bytes   <= '0;
      stat_bubbles <= '0;
      keep_err     <= 1'b0;
      unf_err      <= 1'b0;
    end else begin
      rdy_q   <= tx_rdyout;
      unf_err <= unf_err | tx_unfout;
      for (int i = 0; i < NSEG; i++) begin
        seg_reg[i].ena <= seg_next[i].ena;
        seg_reg[i].sop <= seg_next[i].sop;
        seg_reg[i].eop <= seg_next[i].eop;
        seg_reg[i].err <= seg_next[i].err;
        if (acc) begin
          seg_reg[i].data <= seg_next[i].data;
          seg_reg[i].mty  <= seg_next[i].mty;
        end
      end
      if (acc) begin
        stat_bytes <= stat_bytes + (s_axis.tlast ? BYTE_CNT_W'(last_bytes) : BYTE_CNT_W'(64));
        if (s_axis.tlast || bad_nonlast) stat_pkts <= stat_pkts + 32'd1;
        if (bad_keep) keep_err <= 1'b1;
      end
      if (state_reg == IN_PKT && rdy_q && !s_axis.tvalid && stat_bubbles != 16'hFFFF)
        stat_bubbles <= stat_bubbles + 16'd1;
    end
  end

  assign tx_datain0 = seg_reg[0].data;  assign tx_datain1 = seg_reg[1].data;
  assign tx_datain2 = seg_reg[2].data;  assign tx_datain3 = seg_reg[3].data;
  assign tx_enain0  = seg_reg[0].ena;   assign tx_enain1  = seg_reg[1].ena;
  assign tx_enain2  = seg_reg[2].ena;   assign tx_enain3  = seg_reg[3].ena;
  assign tx_sopin0  = seg_reg[0].sop;   assign tx_sopin1  = seg_reg[1].sop;
  assign tx_sopin2  = seg_reg[2].sop;   assign tx_sopin3  = seg_reg[3].sop;
  assign tx_eopin0  = seg_reg[0].eop;   assign tx_eopin1  = seg_reg[1].eop;
  assign tx_eopin2  = seg_reg[2].eop;   assign tx_eopin3  = seg_reg[3].eop;
  assign tx_errin0  = seg_reg[0].err;   assign tx_errin1  = seg_reg[1].err;
  assign tx_errin2  = seg_reg[2].err;   assign tx_errin3  = seg_reg[3].err;
  assign tx_mtyin0  = seg_reg[0].mty;   assign tx_mtyin1  = seg_reg[1].mty;
  assign tx_mtyin2  = seg_reg[2].mty;   assign tx_mtyin3  = seg_reg[3].mty;
endmodule

// File: doc/axis2lbus_tx.md
Name: axis2lbus_tx

Overview:
- Converts a 512-bit AXI4-Stream packet stream into the 4-segment LBUS transmit interface of the 100G CMAC.
- Sits between the user TX datapath (AXIS master) and the CMAC tx_* LBUS ports.
- Each 128-bit segment's tkeep is converted to an LBUS mty through four keep2mty instances.
- Adds SOP/EOP framing, error forwarding, protocol checking and TX statistics.

Parameters:
- NSEG, 4, number of LBUS segments; fixed at 4; the AXIS width is NSEG*128.
- BYTE_CNT_W, 48, width of the transmitted-byte counter.

Ports:
- clk  in  1  core clock, the CMAC tx_clk_out domain
- rst_n  in  1  synchronous, active-low reset
- s_axis_tdata  in  512  packet data; byte 0 is bits [7:0]
- s_axis_tkeep  in  64  byte enables; contiguous from bit 0
- s_axis_tlast  in  1  last beat of packet
- s_axis_tuser  in  1  packet error; sampled on the tlast beat
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accepted when tvalid&tready
- tx_datain0..3  out  128 each  segment data, big-endian
- tx_enain0..3  out  1 each  segment enable
- tx_sopin0..3  out  1 each  start of packet
- tx_eopin0..3  out  1 each  end of packet
- tx_errin0..3  out  1 each  packet error, valid with eop
- tx_mtyin0..3  out  4 each  empty bytes in segment, valid with eop
- tx_rdyout  in  1  CMAC ready
- tx_unfout  in  1  CMAC underflow indication
- stat_pkts  out  32  packets sent; wraps
- stat_bytes  out  BYTE_CNT_W  bytes sent; wraps
- stat_bubbles  out  16  mid-packet bubbles; saturates at 0xFFFF
- keep_err  out  1  sticky: illegal tkeep seen
- unf_err  out  1  sticky: tx_unfout seen

Behaviour:
- Reset: every output is 0, including s_axis_tready; the FSM is in IDLE and all counters are 0. Reset mid-packet drops the partial packet with no EOP emitted. After rst_n rises, the first accepted beat carries SOP.
- rdy_q is tx_rdyout registered. s_axis_tready = rdy_q. This gives one cycle of overrun after tx_rdyout drops, which the CMAC tolerates.
- Latency: an accepted beat appears on tx_* in the next cycle, all outputs registered. In a cycle with no accepted beat, all ena/sop/eop/err are 0 and data/mty hold their previous values.
- Segment mapping: segment i carries AXIS bytes 16i..16i+15. AXIS byte 16i+k goes to tx_datain_i[127-8k -: 8].
- mty_i comes from keep2mty applied to the bit-reversed tkeep[16i+15:16i]. For n valid bytes, mty = 16-n. It is forced to 0 on segments without eop.
- FSM:
  - IDLE --accepted beat, !tlast--> IN_PKT
  - IDLE --accepted beat, tlast--> IDLE
  - IN_PKT --accepted beat, tlast--> IDLE
  - Otherwise the FSM holds its state.
- sop0 = accepted beat && state==IDLE. sop1..3 are always 0.
- Non-last beat: all four segments enabled, no eop.
- Last beat:
  - The eop segment e is the highest i with any keep bit set.
  - ena_i = (i <= e); eop_e = 1; err_e = tuser.
- keep_err (sticky) is set on any of these, and the affected segment gets err=1 and eop:
  - a non-last beat with keep != all ones;
  - a non-contiguous tkeep;
  - a last beat with tkeep==0. In this case e=0, mty0=0 and err0=1.
- A non-last beat with an illegal keep is forced to terminate the packet: eop and err go on segment 3 and the FSM returns to IDLE. The remaining beats of that packet are then sent as a new packet.
- Bubble: state==IN_PKT && s_axis_tready && !s_axis_tvalid increments stat_bubbles (saturating).
- Statistics:
  - stat_pkts increments by 1 on each emitted eop.
  - stat_bytes adds 64 per non-last beat, and 16*e + (16 - mty_e) on a last beat.
- unf_err is set when tx_unfout==1 and cleared only by reset.

Decomposition:
- Shared package (lbus_pkg) holds SEG_W=128, SEG_BYTES=16, MTY_W=4, NSEG=4, a keep_rev16 function, and the segment struct {data, ena, sop, eop, err, mty}.
- Sub-module: keep2mty, instantiated ×4, one per segment.
- The FSM, counters and output registers live in the top module.

Test Plan:
- Single 64B packet, tkeep=all ones, tlast, tuser=0 -> next cycle ena0..3=1, sop0=1, eop3=1, mty3=0; stat_pkts=1, stat_bytes=64.
- 130B packet, beats keep=all ones, all ones, 0x3 tlast -> beat3 ena0 only, eop0=1, mty0=14; stat_bytes=130; sop0 only on first output beat.
- 100B packet with tuser=1, beats keep=all ones, 0xFFFFFFFFF tlast -> last beat ena0..2, eop2=1, err2=1, mty2=12.
- tx_rdyout low for 3 cycles mid-packet -> tready falls one cycle later and no new ena while tready=0; resume without a repeated sop; stat_bubbles unchanged.
- tvalid low 2 cycles mid-packet with tready=1 -> stat_bubbles=2.
- Non-last beat keep=0x00FF..FF -> keep_err=1, eop3=1, err3=1, FSM IDLE, next beat has sop0=1.
- rst_n low for 1 cycle mid-packet -> all outputs 0, tready=0; first beat after recovery has sop0=1; counters 0.
